mesi_cache_ctrl: RTL and testbench
==================================

# mesi_cache_ctrl

Parametrised MESI coherence controller for one private cache: a direct-mapped tag/state array of 2**IDX_W lines plus a request FSM with states IDLE, WAITWB, WAITINV and WAITRD. It serves CPU load/store requests, issues bus transactions and snoops other caches' bus traffic. It adds the EXCLUSIVE state, silent E->M upgrade, victim writeback and upgrade-race recovery to the earlier single-line M/S/I state machine. Data storage is outside this block; only tags and coherence state live here.

## Interface
- IDX_W, 4, index bits; NLINES = 2**IDX_W
- TAG_W, 8, tag bits; ADDR_W = TAG_W+IDX_W, address = {tag, index}
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_valid  in  1  CPU request present
- cpu_write  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  request line address
- cpu_ready  out  1  request accepted this cycle when high with cpu_valid
- cpu_done  out  1  one-cycle completion pulse (registered)
- cpu_hit  out  1  valid with cpu_done: 1 = completed without bus transaction
- bus_req  out  1  bus transaction request
- bus_cmd  out  2  00 WB, 01 BusRd, 10 BusRdX, 11 BusUpgr
- bus_addr  out  ADDR_W  transaction address
- bus_done  in  1  transaction complete (one-cycle pulse)
- bus_shared  in  1  another cache holds the line; sampled with bus_done
- snoop_valid  in  1  remote transaction on bus
- snoop_cmd  in  2  01 BusRd, 10 BusRdX, 11 BusUpgr (00 ignored)
- snoop_addr  in  ADDR_W  snooped address
- snoop_shared  out  1  registered: snooped line was valid here
- snoop_flush  out  1  registered: snooped line was M; data must be supplied

## Operation
- Line state encoding: I=00, S=01, E=10, M=11. Hit = state != I and tag match.
- cpu_ready = (FSM == IDLE) && !snoop_valid. Snoops stall acceptance and never race an accepted lookup.
- Accepted request (IDLE):
  - Load hit: no state change, done/hit.
  - Store hit in M: no change, done/hit.
  - Store hit in E: line to M (silent), done/hit.
  - Store hit in S: -> WAITINV, BusUpgr.
  - Miss with victim in M: -> WAITWB, WB of {victim tag, index}.
  - Miss with victim not M: -> WAITRD, BusRd (load) or BusRdX (store).
- WAITWB on bus_done: victim to I, then -> WAITRD with BusRd/BusRdX for the request address.
- WAITRD on bus_done: tag written. State becomes M for a store, S for a load with bus_shared=1, E for a load with bus_shared=0. Then done (hit=0), -> IDLE.
- WAITINV on bus_done:
  - Line still S: line to M, done (hit=0), -> IDLE.
  - Lost flag set: -> WAITRD with BusRdX.
- Lost flag: set when a snoop invalidates the target line while in WAITINV; cleared on leaving WAITINV.
- Request address and type are latched at acceptance.
- bus_req, bus_cmd and bus_addr are held stable from state entry through the bus_done cycle. All three deassert the cycle after bus_done unless the next state issues a new command.
- Snoops update the array in any FSM state; lookup is tag match on the snoop index.
  - BusRd: M->S (flush), E->S, S->S.
  - BusRdX: M->I (flush), E/S->I.
  - BusUpgr: S->I.
  - Miss: no change, both responses 0.
- The bus never asserts snoop_valid in the same cycle as this block's bus_done. The block does not check this.

## Timing
- Reset: all line states I, tags 0, FSM IDLE, lost=0. All outputs 0 except cpu_ready, which follows its equation (1 when snoop_valid=0).
- Hit accepted in cycle T: array update at edge ending T; cpu_done=1, cpu_hit=1 in T+1. Back-to-back hits give one per cycle.
- Miss accepted in cycle T: bus_req=1 from T+1. bus_done in cycle D: fill at edge ending D, cpu_done in D+1, FSM IDLE in D+1, cpu_ready high in D+1.
- WAITWB->WAITRD: bus_req stays high; cmd/addr change in the cycle after WB bus_done.
- Snoop in cycle S: array updated at edge ending S; snoop_shared/snoop_flush valid in S+1 for one cycle.
- A snoop to the victim during WAITWB updates state normally; the WB still completes and the victim ends at I.
- Reset mid-transaction: everything returns to reset values immediately. No bus handshake completion is owed.

## Test plan
- Load to 0x012 after reset, bus_done with bus_shared=0 -> BusRd to 0x012, line E, cpu_done hit=0. Store to 0x012 -> cpu_done next cycle, hit=1, no bus_req, line M.
- Load 0x034 with bus_shared=1 -> S. Store 0x034 -> BusUpgr; bus_done -> M, done hit=0.
- Line 0x034 in S, store accepted, snoop BusUpgr 0x034 before bus_done -> line I. On bus_done, BusRdX 0x034 issued; second bus_done -> M, single cpu_done.
- Index 2 holds 0x012 in M, load 0x112 -> WB to 0x012, then BusRd 0x112, final E, one cpu_done.
- Line 0x055 in M, snoop BusRd 0x055 -> next cycle shared=1, flush=1, line S. Then snoop BusRdX -> shared=1, flush=0, line I. Snoop to a tag miss -> both 0.
- Reset asserted in WAITRD -> bus_req=0 and all lines I immediately. Subsequent load misses.

Source files
------------

// File: rtl/mesi_cache_ctrl.sv
// MESI coherence controller for one private, direct-mapped cache.
// Holds per-line tag and coherence state (data lives elsewhere), serves
// CPU loads/stores, issues bus transactions and answers remote snoops.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cpu_valid/write/addr CPU request; accepted when cpu_ready is high
//   cpu_ready            IDLE and no snoop this cycle
//   cpu_done/cpu_hit     registered completion pulse, hit = no bus traffic
//   bus_req/cmd/addr     outgoing transaction, held until bus_done
//   bus_done/bus_shared  transaction completion, shared sampled with done
//   snoop_valid/cmd/addr remote transaction
//   snoop_shared/flush   registered snoop response, one cycle after snoop
module mesi_cache_ctrl #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_valid,
    input  logic                   cpu_write,
    input  logic [TAG_W+IDX_W-1:0] cpu_addr,
    output logic                   cpu_ready,
    output logic                   cpu_done,
    output logic                   cpu_hit,
    output logic                   bus_req,
    output logic [1:0]             bus_cmd,
    output logic [TAG_W+IDX_W-1:0] bus_addr,
    input  logic                   bus_done,
    input  logic                   bus_shared,
    input  logic                   snoop_valid,
    input  logic [1:0]             snoop_cmd,
    input  logic [TAG_W+IDX_W-1:0] snoop_addr,
    output logic                   snoop_shared,
    output logic                   snoop_flush
);
    localparam int NLINES = 2**IDX_W;
    localparam int ADDR_W = TAG_W + IDX_W;

    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;
    localparam logic [1:0] CMD_WB = 2'b00, CMD_RD = 2'b01, CMD_RDX = 2'b10, CMD_UPGR = 2'b11;

    typedef enum logic [1:0] {IDLE, WAITWB, WAITINV, WAITRD} state_t;

    logic [TAG_W-1:0] lineTag [NLINES];
    logic [1:0]       lineSt  [NLINES];

    state_t state, nextState;
    logic   reqWrite;
    logic [ADDR_W-1:0] reqAddr;
    logic   lost;

    // CPU-side lookup
    logic [IDX_W-1:0] cpuIdx, reqIdx, snpIdx;
    logic [TAG_W-1:0] cpuTag, reqTag, snpTag;
    logic [1:0]       cpuSt, snpSt, snpNext;
    logic             lookHit, snpHit, snpKill;

    assign cpuIdx  = cpu_addr[IDX_W-1:0];
    assign cpuTag  = cpu_addr[ADDR_W-1:IDX_W];
    assign reqIdx  = reqAddr[IDX_W-1:0];
    assign reqTag  = reqAddr[ADDR_W-1:IDX_W];
    assign snpIdx  = snoop_addr[IDX_W-1:0];
    assign snpTag  = snoop_addr[ADDR_W-1:IDX_W];
    assign cpuSt   = lineSt[cpuIdx];
    assign snpSt   = lineSt[snpIdx];
    assign lookHit = (cpuSt != ST_I) && (lineTag[cpuIdx] == cpuTag);

    // Snoops are refused acceptance slots, so a lookup never sees a
    // same-cycle snoop write to the array.
    assign cpu_ready = (state == IDLE) && !snoop_valid;

    assign snpHit = snoop_valid && (snoop_cmd != CMD_WB) && (snpSt != ST_I) &&
                    (lineTag[snpIdx] == snpTag);

    always_comb begin
        snpNext = snpSt;
        case (snoop_cmd)
            CMD_RD:   snpNext = ST_S;
            CMD_RDX:  snpNext = ST_I;
            CMD_UPGR: snpNext = (snpSt == ST_S) ? ST_I : snpSt;
            default:  snpNext = snpSt;
        endcase
    end

    // A remote invalidation of the line we are upgrading means our copy is
    // stale; the upgrade must be redone as a full read-exclusive.
    assign snpKill = snpHit && (snpNext == ST_I) && (snoop_addr == reqAddr);

    logic              busReqN, doneN, hitN, accept;
    logic [1:0]        busCmdN;
    logic [ADDR_W-1:0] busAddrN;
    logic              hitToM, victimInv, fillEn, upgrDone;
    logic [1:0]        fillSt;

    always_comb begin
        nextState = state;
        busReqN   = bus_req;
        busCmdN   = bus_cmd;
        busAddrN  = bus_addr;
        doneN     = 1'b0;
        hitN      = 1'b0;
        accept    = 1'b0;
        hitToM    = 1'b0;
        victimInv = 1'b0;
        fillEn    = 1'b0;
        fillSt    = ST_I;
        upgrDone  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_valid && cpu_ready) begin
                    accept = 1'b1;
                    if (lookHit && (!cpu_write || cpuSt != ST_S)) begin
                        doneN  = 1'b1;
                        hitN   = 1'b1;
                        hitToM = cpu_write && (cpuSt == ST_E);
                    end else if (lookHit) begin
                        nextState = WAITINV;
                        busReqN   = 1'b1;
                        busCmdN   = CMD_UPGR;
                        busAddrN  = cpu_addr;
                    end else if (cpuSt == ST_M) begin
                        nextState = WAITWB;
                        busReqN   = 1'b1;
                        busCmdN   = CMD_WB;
                        busAddrN  = {lineTag[cpuIdx], cpuIdx};
                    end else begin
                        nextState = WAITRD;
                        busReqN   = 1'b1;
                        busCmdN   = cpu_write ? CMD_RDX : CMD_RD;
                        busAddrN  = cpu_addr;
                    end
                end
            end
            WAITWB: begin
                if (bus_done) begin
                    victimInv = 1'b1;
                    nextState = WAITRD;
                    busCmdN   = reqWrite ? CMD_RDX : CMD_RD;
                    busAddrN  = reqAddr;
                end
            end
            WAITRD: begin
                if (bus_done) begin
                    fillEn    = 1'b1;
                    fillSt    = reqWrite ? ST_M : (bus_shared ? ST_S : ST_E);
                    doneN     = 1'b1;
                    nextState = IDLE;
                    busReqN   = 1'b0;
                    busCmdN   = CMD_WB;
                    busAddrN  = '0;
                end
            end
            WAITINV: begin
                if (bus_done) begin
                    if (lost) begin
                        nextState = WAITRD;
                        busCmdN   = CMD_RDX;
                        busAddrN  = reqAddr;
                    end else begin
                        upgrDone  = 1'b1;
                        doneN     = 1'b1;
                        nextState = IDLE;
                        busReqN   = 1'b0;
                        busCmdN   = CMD_WB;
                        busAddrN  = '0;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req      <= 1'b0;
            bus_cmd      <= CMD_WB;
            bus_addr     <= '0;
            cpu_done     <= 1'b0;
            cpu_hit      <= 1'b0;
            snoop_shared <= 1'b0;
            snoop_flush  <= 1'b0;
            reqWrite     <= 1'b0;
            reqAddr      <= '0;
            lost         <= 1'b0;
        end else begin
            bus_req      <= busReqN;
            bus_cmd      <= busCmdN;
            bus_addr     <= busAddrN;
            cpu_done     <= doneN;
            cpu_hit      <= hitN;
            snoop_shared <= snpHit;
            snoop_flush  <= snpHit && (snpSt == ST_M);
            if (accept) begin
                reqWrite <= cpu_write;
                reqAddr  <= cpu_addr;
            end
            lost <= (state == WAITINV) && (nextState == WAITINV) && (lost || snpKill);
        end
    end

    // Snoop and CPU-side writes never coincide on the same line in a way
    // that matters: the bus keeps snoops away from bus_done, and acceptance
    // is blocked during snoops. CPU-side writes are listed last anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NLINES; i++) begin
                lineTag[i] <= '0;
                lineSt[i]  <= ST_I;
            end
        end else begin
            if (snpHit)    lineSt[snpIdx] <= snpNext;
            if (hitToM)    lineSt[cpuIdx] <= ST_M;
            if (victimInv) lineSt[reqIdx] <= ST_I;
            if (fillEn) begin
                lineTag[reqIdx] <= reqTag;
                lineSt[reqIdx]  <= fillSt;
            end
            if (upgrDone)  lineSt[reqIdx] <= ST_M;
        end
    end
endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Bench for mesi_cache_ctrl: directed vector table from the test plan,
// a reset-in-flight sequence, then randomized traffic checked against a
// transaction-level MESI model.
module tb_mesi_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid, cpu_write;
    logic [11:0] cpu_addr;
    logic        cpu_ready, cpu_done, cpu_hit;
    logic        bus_req;
    logic [1:0]  bus_cmd;
    logic [11:0] bus_addr;
    logic        bus_done, bus_shared;
    logic        snoop_valid;
    logic [1:0]  snoop_cmd;
    logic [11:0] snoop_addr;
    logic        snoop_shared, snoop_flush;

    mesi_cache_ctrl #(.IDX_W(4), .TAG_W(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_done(bus_done), .bus_shared(bus_shared),
        .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
        .snoop_shared(snoop_shared), .snoop_flush(snoop_flush)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model (spec rules on plain arrays) -------
    int         mSt  [16];   // 0=I 1=S 2=E 3=M
    logic [7:0] mTag [16];

    function automatic void mReset();
        for (int i = 0; i < 16; i++) begin mSt[i] = 0; mTag[i] = 8'h0; end
    endfunction

    function automatic void mSnoop(input logic [1:0] cmd, input logic [11:0] a,
                                   output bit sh, output bit fl);
        int ix;
        bit h;
        ix = int'(a[3:0]);
        h  = (cmd != 2'b00) && (mSt[ix] != 0) && (mTag[ix] == a[11:4]);
        sh = h;
        fl = h && (mSt[ix] == 3);
        if (h) begin
            if (cmd == 2'b01)                       mSt[ix] = 1;
            else if (cmd == 2'b10)                  mSt[ix] = 0;
            else if (cmd == 2'b11 && mSt[ix] == 1)  mSt[ix] = 0;
        end
    endfunction

    function automatic void mCpu(input bit wr, input logic [11:0] a, input bit sh,
                                 input bit inj, input logic [1:0] iCmd, input logic [11:0] iAddr,
                                 output bit hit, output int n, output logic [2:0][13:0] lg,
                                 output bit iSh, output bit iFl);
        int ix;
        bit v, wb;
        logic [1:0] rd;
        ix = int'(a[3:0]);
        v  = (mSt[ix] != 0) && (mTag[ix] == a[11:4]);
        rd = wr ? 2'b10 : 2'b01;
        hit = 0; n = 0; lg = '0; iSh = 0; iFl = 0;
        if (v && (!wr || mSt[ix] != 1)) begin
            hit = 1;
            if (wr) mSt[ix] = 3;
            return;
        end
        if (v) begin
            lg[0] = {2'b11, a}; n = 1;
            if (inj) mSnoop(iCmd, iAddr, iSh, iFl);
            if (mSt[ix] == 0) begin lg[1] = {2'b10, a}; n = 2; end
            mSt[ix] = 3;
            return;
        end
        wb = (mSt[ix] == 3);
        if (wb) lg[0] = {2'b00, mTag[ix], a[3:0]};
        else    lg[0] = {rd, a};
        n = 1;
        if (inj) mSnoop(iCmd, iAddr, iSh, iFl);
        if (wb) begin mSt[ix] = 0; lg[1] = {rd, a}; n = 2; end
        mTag[ix] = a[11:4];
        mSt[ix]  = wr ? 3 : (sh ? 1 : 2);
    endfunction

    // ---------------- drivers ----------------
    task automatic doSnoop(input logic [1:0] cmd, input logic [11:0] a,
                           output bit sh, output bit fl, output bit rdy);
        @(negedge clk);
        snoop_valid = 1; snoop_cmd = cmd; snoop_addr = a;
        #1 rdy = cpu_ready;
        @(negedge clk);
        snoop_valid = 0;
        sh = snoop_shared; fl = snoop_flush;
    endtask

    // Issues one CPU request and plays the bus agent until cpu_done.
    // Optionally injects one snoop in the first cycle of the first bus
    // transaction. timeOk covers done latency, bus hold, single pulse.
    task automatic doCpu(input bit wr, input logic [11:0] a, input bit sh,
                         input bit inj, input logic [1:0] iCmd, input logic [11:0] iAddr,
                         output bit gotDone, output bit hit, output int nBus,
                         output logic [2:0][13:0] busLog, output bit iSh, output bit iFl,
                         output bit timeOk);
        bit inTxn, injUsed;
        int dly, lastDone, w;
        gotDone = 0; hit = 0; nBus = 0; busLog = '0; iSh = 0; iFl = 0; timeOk = 1;
        inTxn = 0; injUsed = 0; dly = 0; lastDone = -100; w = 0;
        @(negedge clk);
        cpu_valid = 1; cpu_write = wr; cpu_addr = a;
        #1;
        while (!cpu_ready && w < 20) begin @(negedge clk); #1; w++; end
        @(negedge clk);
        cpu_valid = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            bus_done = 0;
            if (snoop_valid) begin
                snoop_valid = 0; iSh = snoop_shared; iFl = snoop_flush;
            end
            if (cpu_done) begin
                gotDone = 1;
                hit = cpu_hit;
                if (nBus == 0) begin if (cyc != 1) timeOk = 0; end
                else if (cyc != lastDone + 1) timeOk = 0;
                break;
            end
            if (bus_req) begin
                if (!inTxn) begin
                    if (nBus < 3) busLog[nBus] = {bus_cmd, bus_addr};
                    nBus++;
                    inTxn = 1;
                    dly = $urandom_range(0, 2);
                    if (inj && !injUsed) begin
                        injUsed = 1;
                        snoop_valid = 1; snoop_cmd = iCmd; snoop_addr = iAddr;
                        dly++;
                    end
                end else if (nBus <= 3 && {bus_cmd, bus_addr} !== busLog[nBus-1]) timeOk = 0;
                if (dly == 0) begin
                    bus_done = 1; bus_shared = sh; inTxn = 0; lastDone = cyc;
                end else dly--;
            end
            @(negedge clk);
        end
        if (gotDone) begin
            @(negedge clk);
            if (cpu_done || bus_req) timeOk = 0;
        end
        bus_done = 0; snoop_valid = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit               isSnp;
        bit               wr;
        logic [11:0]      addr;
        bit               sh;
        logic [1:0]       sCmd;
        bit               inj;
        logic [1:0]       injCmd;
        logic [11:0]      injAddr;
        bit               expHit;
        int               expN;
        logic [2:0][13:0] expBus;
        bit               expSh;
        bit               expFl;
        logic [1:0]       expSt;
    } vec_t;

    function automatic vec_t mkCpu(bit wr, logic [11:0] a, bit sh, bit eh, int en,
                                   logic [13:0] b0, logic [13:0] b1, logic [1:0] st);
        vec_t v;
        v.isSnp = 0; v.wr = wr; v.addr = a; v.sh = sh; v.sCmd = 0;
        v.inj = 0; v.injCmd = 0; v.injAddr = 0;
        v.expHit = eh; v.expN = en; v.expBus = '0; v.expBus[0] = b0; v.expBus[1] = b1;
        v.expSh = 0; v.expFl = 0; v.expSt = st;
        return v;
    endfunction

    function automatic vec_t mkSnp(logic [1:0] cmd, logic [11:0] a, bit esh, bit efl, logic [1:0] st);
        vec_t v;
        v = mkCpu(0, a, 0, 0, 0, 14'h0, 14'h0, st);
        v.isSnp = 1; v.sCmd = cmd; v.expSh = esh; v.expFl = efl;
        return v;
    endfunction

    function automatic vec_t withInj(vec_t vi, logic [1:0] cmd, logic [11:0] a, bit esh, bit efl);
        vec_t v;
        v = vi;
        v.inj = 1; v.injCmd = cmd; v.injAddr = a; v.expSh = esh; v.expFl = efl;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        bit gd, ht, ish, ifl, tok, sh, fl, rdy, allI, mh, msh, mfl;
        int nb, mn, ix;
        logic [2:0][13:0] bl, mbl;
        vec_t v;

        rst = 1; cpu_valid = 0; cpu_write = 0; cpu_addr = 0;
        bus_done = 0; bus_shared = 0; snoop_valid = 0; snoop_cmd = 0; snoop_addr = 0;

        tbl.push_back(mkCpu(0, 12'h012, 0, 0, 1, 14'h1012, 14'h0, 2'd2));
        tbl.push_back(mkCpu(1, 12'h012, 0, 1, 0, 14'h0,    14'h0, 2'd3));
        tbl.push_back(mkCpu(0, 12'h034, 1, 0, 1, 14'h1034, 14'h0, 2'd1));
        tbl.push_back(mkCpu(1, 12'h034, 0, 0, 1, 14'h3034, 14'h0, 2'd3));
        tbl.push_back(mkSnp(2'b01, 12'h034, 1, 1, 2'd1));
        tbl.push_back(withInj(mkCpu(1, 12'h034, 0, 0, 2, 14'h3034, 14'h2034, 2'd3),
                              2'b11, 12'h034, 1, 0));
        tbl.push_back(mkCpu(0, 12'h112, 0, 0, 2, 14'h0012, 14'h1112, 2'd2));
        tbl.push_back(mkCpu(1, 12'h055, 0, 0, 1, 14'h2055, 14'h0, 2'd3));
        tbl.push_back(mkSnp(2'b01, 12'h055, 1, 1, 2'd1));
        tbl.push_back(mkSnp(2'b10, 12'h055, 1, 0, 2'd0));
        tbl.push_back(mkSnp(2'b01, 12'h212, 0, 0, 2'd2));
        tbl.push_back(mkSnp(2'b01, 12'h112, 1, 0, 2'd1));
        tbl.push_back(mkCpu(0, 12'h112, 0, 1, 0, 14'h0,    14'h0, 2'd1));
        tbl.push_back(mkCpu(1, 12'h112, 0, 0, 1, 14'h3112, 14'h0, 2'd3));
        tbl.push_back(mkSnp(2'b10, 12'h112, 1, 1, 2'd0));
        tbl.push_back(mkCpu(1, 12'h012, 0, 0, 1, 14'h2012, 14'h0, 2'd3));
        tbl.push_back(withInj(mkCpu(0, 12'h212, 1, 0, 2, 14'h0012, 14'h1212, 2'd1),
                              2'b01, 12'h012, 1, 1));
        tbl.push_back(mkSnp(2'b11, 12'h212, 1, 0, 2'd0));
        tbl.push_back(mkCpu(0, 12'h212, 0, 0, 1, 14'h1212, 14'h0, 2'd2));
        tbl.push_back(mkCpu(1, 12'h212, 0, 1, 0, 14'h0,    14'h0, 2'd3));
        tbl.push_back(mkCpu(0, 12'h212, 0, 1, 0, 14'h0,    14'h0, 2'd3));

        // reset state: {ready, req, cmd, addr, done, hit, shared, flush}
        @(negedge clk); @(negedge clk);
        chk("reset_outputs_in_rst",
            {cpu_ready, bus_req, bus_cmd, bus_addr, cpu_done, cpu_hit, snoop_shared, snoop_flush},
            {1'b1, 1'b0, 2'b00, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 0;
        @(negedge clk);
        chk("reset_outputs_after", {cpu_ready, bus_req, cpu_done, snoop_shared, snoop_flush}, 5'b10000);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.isSnp) begin
                doSnoop(v.sCmd, v.addr, sh, fl, rdy);
                chk($sformatf("v%0d_snoop_shared", i), sh, v.expSh);
                chk($sformatf("v%0d_snoop_flush", i), fl, v.expFl);
                chk($sformatf("v%0d_ready_during_snoop", i), rdy, 0);
            end else begin
                doCpu(v.wr, v.addr, v.sh, v.inj, v.injCmd, v.injAddr, gd, ht, nb, bl, ish, ifl, tok);
                chk($sformatf("v%0d_done", i), gd, 1);
                chk($sformatf("v%0d_hit", i), ht, v.expHit);
                chk($sformatf("v%0d_nbus", i), nb, v.expN);
                for (int k = 0; k < v.expN && k < 3; k++)
                    chk($sformatf("v%0d_bus%0d_cmdaddr", i, k), bl[k], v.expBus[k]);
                chk($sformatf("v%0d_timing", i), tok, 1);
                if (v.inj) begin
                    chk($sformatf("v%0d_inj_shared", i), ish, v.expSh);
                    chk($sformatf("v%0d_inj_flush", i), ifl, v.expFl);
                end
            end
            chk($sformatf("v%0d_line_state", i), dut.lineSt[int'(v.addr[3:0])], v.expSt);
        end

        // reset while waiting for a read
        @(negedge clk);
        cpu_valid = 1; cpu_write = 0; cpu_addr = 12'h0A9;
        @(negedge clk);
        cpu_valid = 0;
        chk("rst_mid_busreq_before", bus_req, 1);
        rst = 1;
        #1;
        chk("rst_mid_busreq_after", bus_req, 0);
        allI = 1;
        for (int i = 0; i < 16; i++) if (dut.lineSt[i] != 2'b00) allI = 0;
        chk("rst_mid_all_invalid", allI, 1);
        chk("rst_mid_ready", cpu_ready, 1);
        @(negedge clk);
        rst = 0;
        doCpu(0, 12'h212, 0, 0, 2'b00, 12'h0, gd, ht, nb, bl, ish, ifl, tok);
        chk("post_rst_done", gd, 1);
        chk("post_rst_hit", ht, 0);
        chk("post_rst_nbus", nb, 1);
        chk("post_rst_cmdaddr", bl[0], 14'h1212);

        // randomized traffic against the model
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        mReset();
        for (int n = 0; n < 250; n++) begin
            logic [11:0] a, ia;
            logic [1:0]  c, ic;
            bit wr, bsh, inj;
            a  = {6'h0, 2'($urandom_range(0, 3)), 2'b0, 2'($urandom_range(0, 3))};
            ix = int'(a[3:0]);
            if ($urandom_range(0, 9) < 4) begin
                c = 2'($urandom_range(0, 3));
                mSnoop(c, a, msh, mfl);
                doSnoop(c, a, sh, fl, rdy);
                chk($sformatf("r%0d_snoop_shared", n), sh, msh);
                chk($sformatf("r%0d_snoop_flush", n), fl, mfl);
            end else begin
                wr  = 1'($urandom_range(0, 1));
                bsh = 1'($urandom_range(0, 1));
                inj = ($urandom_range(0, 3) == 0);
                ic  = 2'($urandom_range(1, 3));
                ia  = {6'h0, 2'($urandom_range(0, 3)), 2'b0, 2'($urandom_range(0, 3))};
                mCpu(wr, a, bsh, inj, ic, ia, mh, mn, mbl, msh, mfl);
                doCpu(wr, a, bsh, inj, ic, ia, gd, ht, nb, bl, ish, ifl, tok);
                chk($sformatf("r%0d_done", n), gd, 1);
                chk($sformatf("r%0d_hit", n), ht, mh);
                chk($sformatf("r%0d_nbus", n), nb, mn);
                for (int k = 0; k < mn && k < 3; k++)
                    chk($sformatf("r%0d_bus%0d_cmdaddr", n, k), bl[k], mbl[k]);
                chk($sformatf("r%0d_timing", n), tok, 1);
                if (inj && mn > 0) begin
                    chk($sformatf("r%0d_inj_shared", n), ish, msh);
                    chk($sformatf("r%0d_inj_flush", n), ifl, mfl);
                end
            end
            chk($sformatf("r%0d_line_state", n), dut.lineSt[ix], mSt[ix]);
        end
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("final_state_%0d", i), dut.lineSt[i], mSt[i]);
            if (mSt[i] != 0) chk($sformatf("final_tag_%0d", i), dut.lineTag[i], mTag[i]);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
